pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage RV32I pipeline. It drives enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB from three sources:
- load-use hazards between ID and EX;
- taken branches and jumps resolved in EX;
- a req/ack handshake with data memory (DMEM), guarded by a timeout.

It also keeps saturating stall and flush performance counters.

Parameters:
MEM_TIMEOUT, 16, max cycles a DMEM access waits for ack before error halt (>=2)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
instr_IFID  in  32  instruction held in IF/ID
instr_IDEX  in  32  instruction held in ID/EX
instr_EXMEM  in  32  instruction held in EX/MEM (MEM stage)
branch_taken_EX  in  1  branch/JAL/JALR in EX redirects PC this cycle
dmem_ack  in  1  DMEM completes the current access this cycle
dmem_req  out  1  MEM-stage load/store requests DMEM
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID loads NOP (0x00000013)
idex_en  out  1  ID/EX load enable
idex_flush  out  1  ID/EX loads bubble (NOP, RegWEn=0)
exmem_en  out  1  EX/MEM load enable
memwb_flush  out  1  MEM/WB loads bubble (RegWEn=0)
dmem_err  out  1  sticky timeout error; pipeline halted
stall_cycles  out  CNT_W  count of cycles with pc_en=0
flush_count  out  CNT_W  count of taken-branch flushes

Behaviour:
- Decode classes from opcode [6:0]:
  - is_load = 0000011; is_store = 0100011; memop = is_load | is_store.
  - uses_rs1: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - uses_rs2: 0110011, 0100011, 1100011.
- load_use = is_load(IDEX) && rd(IDEX)!=0 && ((uses_rs1(IFID) && rs1(IFID)==rd(IDEX)) || (uses_rs2(IFID) && rs2(IFID)==rd(IDEX))).
- dmem_req = memop(EXMEM) && state!=ERR. It is combinational and held stable until ack.
- FSM states:
  - IDLE: mem_stall = memop(EXMEM) && !dmem_ack. On mem_stall -> WAIT, timer <= 1.
  - WAIT: mem_stall = !dmem_ack. On ack -> IDLE. Otherwise timer++. If timer == MEM_TIMEOUT-1 and no ack -> ERR.
  - ERR: all enables 0, all flushes 0, dmem_req 0, dmem_err=1. Left only by reset.
- Priority: ERR > mem_stall > branch_taken_EX > load_use. Output values per condition:
  - mem_stall: pc_en=ifid_en=idex_en=exmem_en=0, memwb_flush=1, no other flush.
  - branch: all en=1, ifid_flush=1, idex_flush=1. load_use is ignored because the younger instructions are squashed.
  - load_use: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1.
  - none: all en=1, all flush=0.
- Ack cycle (IDLE with same-cycle ack, or WAIT with ack): no stall, and the pipeline advances that cycle. A zero-wait DMEM therefore never stalls.
- A branch coinciding with mem_stall is held, not lost: ID/EX and EX/MEM are frozen, so branch_taken_EX re-asserts after the stall.
- Counters:
  - stall_cycles increments on every cycle with pc_en=0 outside ERR.
  - flush_count increments on every cycle in which the branch flush fires.
  - Both saturate at all-ones.
- Reset (async, mid-access included): state=IDLE, timer=0, counters=0, dmem_err=0. Combinational outputs then follow the IDLE rules.

Decomposition:
- Shared package pipe_pkg holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JALR);
  - NOP constant 32'h00000013;
  - FSM state enum {IDLE, WAIT, ERR}.
- One natural sub-module: hazard_decode, the purely combinational rs/rd extraction and load_use logic.

Test Plan:
- IDEX=lw x5,0(x1), IFID=add x6,x5,x2 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; stall_cycles 0->1. Next cycle all en=1.
- IDEX=lw x0,0(x1), IFID=add x6,x0,x2 -> no stall; stall_cycles stays 0.
- branch_taken_EX=1 with load_use also true -> ifid_flush=1, idex_flush=1, pc_en=1; flush_count=1.
- EXMEM=sw, dmem_ack low for 3 cycles then high -> dmem_req=1 for 4 cycles; pc_en=0 and memwb_flush=1 for 3 cycles; stall_cycles=3; IDLE after ack.
- MEM_TIMEOUT=4, EXMEM=lw, ack never -> dmem_err=1 from the 5th cycle; all en=0, dmem_req=0; held until reset, which clears dmem_err and counters.
- Reset asserted while in WAIT -> outputs immediately follow IDLE rules, counters=0; a new access afterwards completes normally.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control slice: opcodes, the canonical NOP,
// DMEM handshake FSM states and small opcode-class helpers.
package pipe_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } mem_state_e;

    function automatic logic is_memop(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return (op == OP_RTYPE) || (op == OP_ITYPE) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JALR);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_RTYPE) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/hazard_decode.sv
// Purely combinational load-use detection between the ID and EX stages.
module hazard_decode
    import pipe_pkg::*;
(
    input  logic [31:0] instr_ifid,
    input  logic [31:0] instr_idex,
    output logic        load_use
);

    logic [4:0] rs1_ifid;
    logic [4:0] rs2_ifid;
    logic [4:0] rd_idex;
    logic       unused_instr_bits;

    assign rs1_ifid = instr_ifid[19:15];
    assign rs2_ifid = instr_ifid[24:20];
    assign rd_idex  = instr_idex[11:7];

    // Fields outside opcode/rs/rd carry no hazard information
    assign unused_instr_bits = ^{instr_ifid[31:25], instr_ifid[14:7], instr_idex[31:12]};

    // A load in EX whose nonzero destination is read by the instruction in ID
    always_comb begin
        load_use = 1'b0;
        if ((instr_idex[6:0] == OP_LOAD) && (rd_idex != 5'd0)) begin
            load_use = (uses_rs1(instr_ifid[6:0]) && (rs1_ifid == rd_idex)) ||
                       (uses_rs2(instr_ifid[6:0]) && (rs2_ifid == rd_idex));
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage RV32I pipeline: load-use stalls,
// branch flushes, DMEM req/ack stalls with timeout halt, and saturating perf counters.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr_IFID,
    input  logic [31:0]      instr_IDEX,
    input  logic [31:0]      instr_EXMEM,
    input  logic             branch_taken_EX,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_flush,
    output logic             dmem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int            TW         = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(MEM_TIMEOUT - 1);

    mem_state_e       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             load_use;
    logic             exmem_memop;
    logic             mem_stall;
    logic             in_err;
    logic             unused_exmem_bits;

    hazard_decode u_hazard_decode (
        .instr_ifid (instr_IFID),
        .instr_idex (instr_IDEX),
        .load_use   (load_use)
    );

    assign exmem_memop       = is_memop(instr_EXMEM[6:0]);
    assign unused_exmem_bits = ^instr_EXMEM[31:7];
    assign in_err            = (state_q == ERR);

    // DMEM handshake: decide the memory stall and the next state/timeout timer
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        mem_stall = 1'b0;
        case (state_q)
            IDLE: begin
                mem_stall = exmem_memop && !dmem_ack;
                if (mem_stall) begin
                    state_d = WAIT;
                    timer_d = TW'(1);
                end
            end
            WAIT: begin
                mem_stall = !dmem_ack;
                if (dmem_ack) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = ERR;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = ERR;
            end
        endcase
    end

    // Stage enables and flushes, priority: error halt > memory stall > branch > load-use
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        dmem_req    = exmem_memop && !in_err;
        if (in_err) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
        end else if (mem_stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (branch_taken_EX) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Saturating performance counters, frozen once the pipeline is halted
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (!in_err) begin
            if (!pc_en && (stall_cycles_q != '1)) begin
                stall_cycles_d = stall_cycles_q + CNT_W'(1);
            end
            if (ifid_flush && (flush_count_q != '1)) begin
                flush_count_d = flush_count_q + CNT_W'(1);
            end
        end
    end

    // State, timer and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign dmem_err     = in_err;
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_pipeline_hazard_ctrl;
    import pipe_pkg::*;

    localparam int MEM_TO  = 4;
    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic [31:0]   instr_IFID, instr_IDEX, instr_EXMEM;
    logic          branch_taken_EX, dmem_ack;
    logic          dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic          exmem_en, memwb_flush, dmem_err;
    logic [CW-1:0] stall_cycles, flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state: halted flag, consecutive unacked stall cycles, counters
    bit m_halted  = 0;
    int m_run     = 0;
    int m_stalls  = 0;
    int m_flushes = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TO), .CNT_W(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_IFID      (instr_IFID),
        .instr_IDEX      (instr_IDEX),
        .instr_EXMEM     (instr_EXMEM),
        .branch_taken_EX (branch_taken_EX),
        .dmem_ack        (dmem_ack),
        .dmem_req        (dmem_req),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_en         (idex_en),
        .idex_flush      (idex_flush),
        .exmem_en        (exmem_en),
        .memwb_flush     (memwb_flush),
        .dmem_err        (dmem_err),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction encoders
    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] enc_sw(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_beq(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, 5'd0, 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b000, rd, 7'b1100111};
    endfunction
    function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'b0110111};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] a, b, c;
        a = 5'($urandom_range(0, 3));
        b = 5'($urandom_range(0, 3));
        c = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 7))
            0: return enc_r(a, b, c);
            1: return enc_lw(a, b);
            2: return enc_sw(a, b);
            3: return enc_beq(a, b);
            4: return enc_addi(a, b, 12'($urandom));
            5: return enc_jalr(a, b);
            6: return enc_lui(a, 20'($urandom));
            default: return NOP;
        endcase
    endfunction

    // Model: which instructions read which source registers
    function automatic bit m_reads_rs1(input logic [31:0] i);
        return i[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
    endfunction
    function automatic bit m_reads_rs2(input logic [31:0] i);
        return i[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction
    function automatic bit m_dep_on_load(input logic [31:0] younger, input logic [31:0] older);
        int dest;
        dest = int'(older[11:7]);
        if (older[6:0] != 7'b0000011 || dest == 0) return 0;
        return (m_reads_rs1(younger) && int'(younger[19:15]) == dest) ||
               (m_reads_rs2(younger) && int'(younger[24:20]) == dest);
    endfunction

    // Model: expected {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, dmem_req, dmem_err}
    function automatic logic [8:0] model_expect();
        bit memop, stall;
        logic req;
        if (m_halted) return 9'b000000001;
        memop = instr_EXMEM[6:0] inside {7'b0000011, 7'b0100011};
        req   = memop;
        stall = (m_run > 0) ? !dmem_ack : (memop && !dmem_ack);
        if (stall)                                  return {7'b0000001, req, 1'b0};
        if (branch_taken_EX)                        return {7'b1111110, req, 1'b0};
        if (m_dep_on_load(instr_IFID, instr_IDEX))  return {7'b0001110, req, 1'b0};
        return {7'b1101010, req, 1'b0};
    endfunction

    function automatic void model_advance();
        logic [8:0] e;
        if (m_halted) return;
        e = model_expect();
        if (!e[8]) m_stalls  = (m_stalls  < CNT_MAX) ? m_stalls  + 1 : CNT_MAX;
        if (e[6])  m_flushes = (m_flushes < CNT_MAX) ? m_flushes + 1 : CNT_MAX;
        if (e[2]) begin
            m_run = m_run + 1;
            if (m_run >= MEM_TO) m_halted = 1;
        end else begin
            m_run = 0;
        end
    endfunction

    function automatic logic [8:0] dut_ctl();
        return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, dmem_req, dmem_err};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] ifid, input logic [31:0] idex, input logic [31:0] exmem,
                                 input logic br, input logic ack);
        instr_IFID      = ifid;
        instr_IDEX      = idex;
        instr_EXMEM     = exmem;
        branch_taken_EX = br;
        dmem_ack        = ack;
    endtask

    // Settle combinational outputs and compare everything against the model
    task automatic checkCycle(input string tag);
        #1;
        checkOutput({tag, "/ctl"}, 64'(dut_ctl()), 64'(model_expect()));
        checkOutput({tag, "/stall_cycles"}, 64'(stall_cycles), 64'(m_stalls));
        checkOutput({tag, "/flush_count"}, 64'(flush_count), 64'(m_flushes));
    endtask

    task automatic advance();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    // Asynchronous reset pulse between clock edges
    task automatic applyReset();
        reset     = 1'b1;
        m_halted  = 0;
        m_run     = 0;
        m_stalls  = 0;
        m_flushes = 0;
        checkCycle("reset");
        reset = 1'b0;
        #1;
    endtask

    typedef struct {
        logic [31:0] ifid;
        logic [31:0] idex;
        logic [31:0] exmem;
        logic        br;
        logic        ack;
        logic [7:0]  exp;
    } vec_t;

    localparam logic [7:0] V_NONE = 8'b11010100;
    localparam logic [7:0] V_LU   = 8'b00011100;
    localparam logic [7:0] V_BR   = 8'b11111100;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{enc_r(6, 5, 2),      enc_lw(5, 1), NOP,          1'b0, 1'b0, V_LU};
        vecs[1]  = '{enc_r(6, 2, 5),      enc_lw(5, 1), NOP,          1'b0, 1'b0, V_LU};
        vecs[2]  = '{enc_r(6, 0, 2),      enc_lw(0, 1), NOP,          1'b0, 1'b0, V_NONE};
        vecs[3]  = '{enc_r(6, 5, 2),      enc_lw(5, 1), NOP,          1'b1, 1'b0, V_BR};
        vecs[4]  = '{enc_r(6, 5, 2),      enc_r(5, 1, 2), NOP,        1'b0, 1'b0, V_NONE};
        vecs[5]  = '{enc_sw(1, 5),        enc_lw(5, 1), NOP,          1'b0, 1'b0, V_LU};
        vecs[6]  = '{enc_addi(6, 7, 12'd5), enc_lw(5, 1), NOP,        1'b0, 1'b0, V_NONE};
        vecs[7]  = '{enc_lui(6, 20'd40),  enc_lw(5, 1), NOP,          1'b0, 1'b0, V_NONE};
        vecs[8]  = '{enc_beq(5, 0),       enc_lw(5, 1), NOP,          1'b0, 1'b0, V_LU};
        vecs[9]  = '{enc_jalr(1, 5),      enc_lw(5, 1), NOP,          1'b0, 1'b0, V_LU};
        vecs[10] = '{NOP,                 NOP,          enc_sw(1, 2), 1'b0, 1'b1, V_NONE | 8'b1};
        vecs[11] = '{enc_r(6, 5, 2),      enc_lw(5, 1), enc_lw(3, 4), 1'b0, 1'b1, V_LU | 8'b1};
        vecs[12] = '{NOP,                 NOP,          NOP,          1'b1, 1'b0, V_BR};
        vecs[13] = '{enc_r(6, 5, 2),      enc_sw(1, 5), NOP,          1'b0, 1'b0, V_NONE};

        reset = 1'b1;
        applyStimulus(NOP, NOP, NOP, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("reset_ctl", 64'(dut_ctl()), 64'(9'b110101000));
        checkOutput("reset_stall_cycles", 64'(stall_cycles), 64'(0));
        checkOutput("reset_flush_count", 64'(flush_count), 64'(0));

        $display("[TB] vector table");
        applyReset();
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].ifid, vecs[i].idex, vecs[i].exmem, vecs[i].br, vecs[i].ack);
            checkCycle($sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d/table", i), 64'(dut_ctl() >> 1), 64'(vecs[i].exp));
            advance();
        end

        $display("[TB] load-use single stall");
        applyReset();
        applyStimulus(enc_r(6, 5, 2), enc_lw(5, 1), NOP, 1'b0, 1'b0);
        checkCycle("lu_stall");
        checkOutput("lu_pc_en", 64'(pc_en), 64'(0));
        checkOutput("lu_ifid_en", 64'(ifid_en), 64'(0));
        checkOutput("lu_idex_flush", 64'(idex_flush), 64'(1));
        advance();
        checkOutput("lu_stall_count", 64'(stall_cycles), 64'(1));
        applyStimulus(enc_r(6, 5, 2), NOP, enc_lw(5, 1), 1'b0, 1'b1);
        checkCycle("lu_resume");
        checkOutput("lu_resume_en", 64'({pc_en, ifid_en, idex_en, exmem_en}), 64'(4'b1111));
        advance();
        checkOutput("lu_resume_count", 64'(stall_cycles), 64'(1));

        $display("[TB] load to x0");
        applyReset();
        applyStimulus(enc_r(6, 0, 2), enc_lw(0, 1), NOP, 1'b0, 1'b0);
        checkCycle("x0");
        advance();
        checkOutput("x0_stall_count", 64'(stall_cycles), 64'(0));

        $display("[TB] branch over load-use");
        applyReset();
        applyStimulus(enc_r(6, 5, 2), enc_lw(5, 1), NOP, 1'b1, 1'b0);
        checkCycle("br");
        checkOutput("br_flushes", 64'({ifid_flush, idex_flush, pc_en}), 64'(3'b111));
        advance();
        checkOutput("br_flush_count", 64'(flush_count), 64'(1));

        $display("[TB] store with three wait cycles");
        applyReset();
        applyStimulus(NOP, NOP, enc_sw(1, 2), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checkCycle("sw_wait");
            checkOutput("sw_wait_req", 64'(dmem_req), 64'(1));
            checkOutput("sw_wait_stall", 64'({pc_en, memwb_flush}), 64'(2'b01));
            advance();
        end
        dmem_ack = 1'b1;
        checkCycle("sw_ack");
        checkOutput("sw_ack_req", 64'(dmem_req), 64'(1));
        checkOutput("sw_ack_pc_en", 64'(pc_en), 64'(1));
        advance();
        checkOutput("sw_stall_count", 64'(stall_cycles), 64'(3));
        applyStimulus(NOP, NOP, NOP, 1'b0, 1'b0);
        checkCycle("sw_idle");
        checkOutput("sw_idle_pc_en", 64'(pc_en), 64'(1));
        advance();

        $display("[TB] DMEM timeout");
        applyReset();
        applyStimulus(NOP, NOP, enc_lw(5, 1), 1'b0, 1'b0);
        for (int k = 0; k < MEM_TO; k++) begin
            checkCycle("to_wait");
            checkOutput("to_wait_err", 64'(dmem_err), 64'(0));
            advance();
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(enc_r(6, 5, 2), enc_lw(5, 1), enc_lw(5, 1), k[0], 1'(k != 0));
            checkCycle("to_halt");
            checkOutput("to_halt_ctl", 64'(dut_ctl()), 64'(9'b000000001));
            advance();
        end
        checkOutput("to_stall_count", 64'(stall_cycles), 64'(MEM_TO));
        applyReset();
        checkOutput("to_reset_err", 64'(dmem_err), 64'(0));
        checkOutput("to_reset_count", 64'(stall_cycles), 64'(0));

        $display("[TB] reset during wait");
        applyStimulus(NOP, NOP, enc_sw(1, 2), 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            checkCycle("rw_wait");
            advance();
        end
        applyReset();
        checkOutput("rw_idle_ctl", 64'(dut_ctl()), 64'(9'b000000110));
        checkOutput("rw_count", 64'(stall_cycles), 64'(0));
        dmem_ack = 1'b1;
        checkCycle("rw_ack");
        checkOutput("rw_ack_pc_en", 64'(pc_en), 64'(1));
        advance();
        applyStimulus(NOP, NOP, NOP, 1'b0, 1'b0);
        checkCycle("rw_after");
        advance();

        $display("[TB] counter saturation");
        applyReset();
        applyStimulus(enc_r(6, 5, 2), enc_lw(5, 1), NOP, 1'b0, 1'b0);
        for (int k = 0; k < CNT_MAX + 5; k++) begin
            checkCycle("sat_stall");
            advance();
        end
        checkOutput("sat_stall_max", 64'(stall_cycles), 64'(CNT_MAX));
        applyStimulus(NOP, NOP, NOP, 1'b1, 1'b0);
        for (int k = 0; k < CNT_MAX + 5; k++) begin
            checkCycle("sat_flush");
            advance();
        end
        checkOutput("sat_flush_max", 64'(flush_count), 64'(CNT_MAX));

        $display("[TB] randomized run");
        applyReset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) == 0) applyReset();
            applyStimulus(rand_instr(), rand_instr(), rand_instr(),
                          1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
            checkCycle("rand");
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
